ps2_key_ctrl: RTL and testbench

- Sequences the PS/2 frame receiver's output into key events for the piano datapath.
- Edge-detects the receiver's frame-valid level and extracts the scan-code byte.
- Runs the Set-2 prefix state machine (E0 extended, F0 break) and suppresses typematic auto-repeat of the held key.
- Buffers resulting make/break events in a small show-ahead FIFO read with a valid/ready handshake.

---
 rtl/ps2_key_ctrl.sv | 89 ++++++++
 tb/tb_ps2_key_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: PS/2 Set-2 scan-code sequencer with repeat filter and show-ahead event FIFO
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_valid,
  input  logic [10:0]                   frame,
  output logic                          ev_valid,
  output logic [9:0]                    ev_data,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          err_proto,
  output logic                          err_ovf,
  input  logic                          clr_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  // bit 0 = extended prefix seen, bit 1 = break prefix seen
  localparam logic [1:0] IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3;
  logic [1:0]    state, state_nx;
  logic          fv_q, acc, bad, is_e0, is_f0, is_pfx, tmo, mk, bk, match;
  logic          ev_push, pop, full, wr, proto_set, ovf_set;
  logic [7:0]    code;
  logic [TW-1:0] tcnt;
  logic [8:0]    held;
  logic          held_vld;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  // byte classification, prefix FSM next state and FIFO control
  always_comb begin
    acc       = frame_valid & ~fv_q;
    code      = frame[8:1];
    bad       = frame[0] | ~frame[10] | (code == 8'h00) | (code == 8'hFF);
    is_e0     = code == 8'hE0;
    is_f0     = code == 8'hF0;
    is_pfx    = is_e0 | is_f0;
    tmo       = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYC - 1));
    match     = held_vld && (held == {state[0], code});
    mk        = acc & ~bad & ~state[1] & ~is_pfx;
    bk        = acc & ~bad & state[1] & ~is_pfx;
    ev_push   = bk | (mk & ~match);
    state_nx  = acc ? ((bad | state[1] | ~is_pfx) ? IDLE : is_e0 ? EXT : {1'b1, state[0]})
                    : tmo ? IDLE : state;
    proto_set = acc ? (bad | (state[1] & is_pfx)) : tmo;
    full      = ev_count == CW'(FIFO_DEPTH);
    ev_valid  = ev_count != '0;
    pop       = ev_valid & ev_ready;
    wr        = ev_push & (~full | pop);
    ovf_set   = ev_push & full & ~pop;
    ev_data   = ev_valid ? mem[rd_ptr] : '0;
  end
  // control state: edge detect, FSM, timeout, held key, FIFO pointers, sticky errors
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fv_q      <= 1'b0;
      state     <= IDLE;
      tcnt      <= '0;
      held      <= '0;
      held_vld  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ev_count  <= '0;
      err_proto <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      fv_q      <= frame_valid;
      state     <= state_nx;
      tcnt      <= (acc | tmo | (state == IDLE)) ? '0 : tcnt + 1'b1;
      if (mk & ~match) begin
        held     <= {state[0], code};
        held_vld <= 1'b1;
      end else if (bk & match) begin
        held_vld <= 1'b0;
      end
      wr_ptr    <= wr_ptr + AW'(wr);
      rd_ptr    <= rd_ptr + AW'(pop);
      ev_count  <= ev_count + CW'(wr) - CW'(pop);
      err_proto <= proto_set | (err_proto & ~clr_err);
      err_ovf   <= ovf_set | (err_ovf & ~clr_err);
    end
  end
  // event storage; contents only matter where the occupancy says so
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {state[0], state[1], code};
  end
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: directed plan steps plus randomized byte stream against a prefix/flag reference model
module tb_ps2_key_ctrl;
  logic        clk = 1'b0, rst = 1'b0, frame_valid = 1'b0, ev_ready = 1'b1, clr_err = 1'b0;
  logic [10:0] frame = '0;
  logic        ev_valid, err_proto, err_ovf;
  logic [9:0]  ev_data;
  logic [3:0]  ev_count;
  int          tests = 0, fails = 0, peak = 0;
  logic [9:0]  got[$], exp[$];
  bit          m_ext, m_brk, m_hv, m_err;
  logic [8:0]  m_held;

  ps2_key_ctrl #(.FIFO_DEPTH(8), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame(frame),
    .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready), .ev_count(ev_count),
    .err_proto(err_proto), .err_ovf(err_ovf), .clr_err(clr_err));

  always #5 clk = ~clk;

  // consumer side: record every event popped, track occupancy high-water mark
  always @(negedge clk) begin
    if (rst && ev_valid && ev_ready) got.push_back(ev_data);
    if (int'(ev_count) > peak) peak = int'(ev_count);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input int hold = 1, input bit good = 1'b1);
    tick();
    frame = {good, ~^b, b, 1'b0};
    frame_valid = 1'b1;
    repeat (hold) tick();
    frame_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic check_q(input string tag);
    chk({tag, " count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk($sformatf("%s ev%0d", tag, i), got[i], exp[i]);
    got.delete();
    exp.delete();
  endtask

  // reference: a byte either resets the prefix flags (error), extends them, or completes a key event
  task automatic model(input logic [7:0] b, input bit good);
    logic [8:0] key;
    key = {m_ext, b};
    if (!good || b == 8'h00 || b == 8'hFF) begin
      m_err = 1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0 || b == 8'hF0) begin
      if (m_brk) begin m_err = 1; m_ext = 0; m_brk = 0; end
      else if (b == 8'hE0) m_ext = 1;
      else m_brk = 1;
    end else begin
      if (m_brk) begin
        exp.push_back({m_ext, 1'b1, b});
        if (m_hv && m_held == key) m_hv = 0;
      end else if (!(m_hv && m_held == key)) begin
        exp.push_back({m_ext, 1'b0, b});
        m_held = key;
        m_hv = 1;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  initial begin
    #3;
    chk("rst ev_valid", ev_valid, 0);
    chk("rst ev_data", ev_data, 0);
    chk("rst ev_count", ev_count, 0);
    chk("rst err_proto", err_proto, 0);
    chk("rst err_ovf", err_ovf, 0);
    tick();
    rst = 1'b1;
    // make then break of 0x1C
    peak = 0;
    send(8'h1C); send(8'hF0); send(8'h1C);
    exp = '{10'h01C, 10'h11C};
    check_q("t1");
    chk("t1 peak", (peak == 1 || peak == 2), 1);
    chk("t1 err_proto", err_proto, 0);
    chk("t1 err_ovf", err_ovf, 0);
    // extended make/break, one level held 500 cycles is a single byte
    send(8'hE0); send(8'h75, 500); send(8'hE0); send(8'hF0); send(8'h75);
    exp = '{10'h275, 10'h375};
    check_q("t2");
    // typematic repeats suppressed
    repeat (4) send(8'h15);
    send(8'hF0); send(8'h15); send(8'h15);
    exp = '{10'h015, 10'h115, 10'h015};
    check_q("t3");
    // break prefix times out back to idle
    send(8'hF0);
    repeat (80) tick();
    chk("t4 before timeout", err_proto, 0);
    repeat (25) tick();
    chk("t4 after timeout", err_proto, 1);
    send(8'h1C);
    exp = '{10'h01C};
    check_q("t4");
    clr_err = 1'b1; tick(); clr_err = 1'b0; tick();
    chk("t4 clr", err_proto, 0);
    // overflow with consumer stalled, then push into full FIFO while popping
    ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(8'h20 + 8'(i));
    chk("t5 full count", ev_count, 8);
    chk("t5 err_ovf", err_ovf, 1);
    chk("t5 head", ev_data, 10'h020);
    frame = {1'b1, ~^8'h29, 8'h29, 1'b0};
    frame_valid = 1'b1;
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    frame_valid = 1'b0;
    repeat (3) tick();
    chk("t5 count after push+pop", ev_count, 8);
    ev_ready = 1'b1;
    repeat (12) tick();
    exp = '{10'h020, 10'h021, 10'h022, 10'h023, 10'h024, 10'h025, 10'h026, 10'h027, 10'h029};
    check_q("t5");
    clr_err = 1'b1; tick(); clr_err = 1'b0; tick();
    chk("t5 clr", err_ovf, 0);
    // async reset in the middle of an extended-break prefix
    ev_ready = 1'b0;
    send(8'h31); send(8'h32); send(8'h33); send(8'hE0); send(8'hF0);
    chk("t6 queued", ev_count, 3);
    #1 rst = 1'b0;
    #1;
    chk("t6 rst ev_valid", ev_valid, 0);
    chk("t6 rst ev_count", ev_count, 0);
    tick();
    rst = 1'b1;
    ev_ready = 1'b1;
    send(8'h1C);
    exp = '{10'h01C};
    check_q("t6");
    chk("t6 err_proto", err_proto, 0);
    // randomized stream against the reference model
    tick(); rst = 1'b0; tick(); rst = 1'b1;
    got.delete();
    exp.delete();
    m_ext = 0; m_brk = 0; m_hv = 0; m_err = 0; m_held = '0;
    for (int n = 0; n < 120; n++) begin
      logic [7:0] b;
      bit good;
      int r;
      r = int'($urandom_range(0, 15));
      b = r < 4 ? 8'hE0 : r < 7 ? 8'hF0 : r < 9 ? 8'h15 : r < 11 ? 8'h75 :
          r == 11 ? ($urandom_range(0, 1) ? 8'hFF : 8'h00) : 8'($urandom_range(1, 254));
      good = $urandom_range(0, 15) != 0;
      send(b, int'($urandom_range(1, 3)), good);
      model(b, good);
      repeat ($urandom_range(0, 4)) tick();
    end
    repeat (4) tick();
    check_q("rand");
    chk("rand err_proto", err_proto, m_err);
    chk("rand err_ovf", err_ovf, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
